// File: rtl/silife_ws2812_pkg.sv
// -----------------------------------------------------------------------------
// silife_pkg
// Shared definitions for the SiLife WS2812 display stage:
//   - state_t      : driver FSM states
//   - GRB_W        : bits per WS2812 pixel (G7..G0 R7..R0 B7..B0)
//   - DEF_*        : default bit/latch timing in clk cycles
//   - max_int()    : helper used to size the shared timing counter
// -----------------------------------------------------------------------------
package silife_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_LATCH
   } state_t;

   localparam int GRB_W     = 24;

   localparam int DEF_T0H   = 4;
   localparam int DEF_T1H   = 8;
   localparam int DEF_BIT   = 12;
   localparam int DEF_RESET = 600;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/silife_ws2812_if.sv
// -----------------------------------------------------------------------------
// silife_ws2812_if
// Scan read-port handshake between a grid consumer and the SiLife grid.
//   row_select : row address driven by the consumer (registered in the consumer)
//   cells      : row contents returned combinationally by the grid, column 0 = MSB
// Modports:
//   master : the display driver (drives row_select, reads cells)
//   slave  : the grid scan port (reads row_select, drives cells)
// -----------------------------------------------------------------------------
interface silife_ws2812_if #(
   parameter int WIDTH  = 32,
   parameter int HEIGHT = 32
);
   logic [$clog2(HEIGHT)-1:0] row_select;
   logic [WIDTH-1:0]          cells;

   modport master (output row_select, input cells);
   modport slave  (input row_select, output cells);
endinterface

// File: rtl/silife_ws2812_bit.sv
// -----------------------------------------------------------------------------
// silife_ws2812_bit
// WS2812 waveform generator. A start pulse launches either one data bit
// (high for T0H/T1H cycles, then low until BIT_CYCLES have elapsed) or a latch
// period (low for RESET_CYCLES). o_done is high during the last cycle of the
// period, so a start issued in that same cycle follows with no gap.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   i_start     : launch a new period (overrides one in progress)
//   i_latch     : with i_start, launch a latch period instead of a data bit
//   i_value     : with i_start, data bit value
//   o_done      : last cycle of the current period
//   o_data      : registered WS2812 data line
// -----------------------------------------------------------------------------
module silife_ws2812_bit
   import silife_pkg::*;
#(
   parameter int T0H_CYCLES   = DEF_T0H,
   parameter int T1H_CYCLES   = DEF_T1H,
   parameter int BIT_CYCLES   = DEF_BIT,
   parameter int RESET_CYCLES = DEF_RESET
) (
   input  logic clk,
   input  logic reset,
   input  logic i_start,
   input  logic i_latch,
   input  logic i_value,
   output logic o_done,
   output logic o_data
);

   localparam int CW = $clog2(max_int(BIT_CYCLES, RESET_CYCLES) + 1);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_last;
   logic [CW-1:0] r_high;
   logic          r_active;
   logic          r_data;

   assign o_done = r_active && (r_cnt == r_last);
   assign o_data = r_data;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt    <= '0;
         r_last   <= '0;
         r_high   <= '0;
         r_active <= 1'b0;
         r_data   <= 1'b0;
      end else if (i_start) begin
         r_active <= 1'b1;
         r_cnt    <= '0;
         if (i_latch) begin
            r_last <= CW'(RESET_CYCLES - 1);
            r_high <= '0;
            r_data <= 1'b0;
         end else begin
            r_last <= CW'(BIT_CYCLES - 1);
            r_high <= i_value ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES);
            r_data <= 1'b1;
         end
      end else if (r_active) begin
         if (o_done) begin
            r_active <= 1'b0;
            r_data   <= 1'b0;
         end else begin
            r_cnt  <= r_cnt + CW'(1);
            // r_cnt+1 is the index of the cycle being entered
            r_data <= (r_cnt + CW'(1)) < r_high;
         end
      end
   end

endmodule

// File: rtl/silife_ws2812.sv
// -----------------------------------------------------------------------------
// silife_ws2812
// Scans the SiLife grid row by row and serialises every cell as a 24-bit GRB
// pixel on a WS2812 data line, followed by a strip latch period.
// Ports:
//   clk, reset       : clock, asynchronous active-low reset
//   i_enable         : driver enable; low aborts a frame into the latch period
//   i_frame          : frame request, sampled only while idle
//   i_serpentine     : reverse pixel order on odd rows
//   i_color_on/off   : GRB colours for live/dead cells (latched per frame)
//   scan             : grid scan port (row_select out, cells in)
//   o_data           : registered WS2812 data line
//   o_busy           : high from frame start through the end of the latch
// -----------------------------------------------------------------------------
module silife_ws2812
   import silife_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int HEIGHT       = 32,
   parameter int T0H_CYCLES   = DEF_T0H,
   parameter int T1H_CYCLES   = DEF_T1H,
   parameter int BIT_CYCLES   = DEF_BIT,
   parameter int RESET_CYCLES = DEF_RESET
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_enable,
   input  logic              i_frame,
   input  logic              i_serpentine,
   input  logic [GRB_W-1:0]  i_color_on,
   input  logic [GRB_W-1:0]  i_color_off,
   silife_ws2812_if.master   scan,
   output logic              o_data,
   output logic              o_busy
);

   localparam int PW = $clog2(WIDTH);
   localparam int RW = $clog2(HEIGHT);
   localparam logic [PW-1:0] LAST_PIX = PW'(WIDTH - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);
   localparam logic [4:0]    LAST_BIT = 5'(GRB_W - 1);

   state_t            r_state;
   logic [RW-1:0]     r_row;
   logic [PW-1:0]     r_pix;
   logic [4:0]        r_bit;
   logic [WIDTH-1:0]  r_row_bits;
   logic [GRB_W-1:0]  r_shift;
   logic [GRB_W-1:0]  r_on;
   logic [GRB_W-1:0]  r_off;
   logic              r_serp;
   logic              r_busy;

   logic              w_rev;
   logic [GRB_W-1:0]  w_load_color;
   logic [GRB_W-1:0]  w_next_color;
   logic              w_start;
   logic              w_latch;
   logic              w_value;
   logic              w_done;

   // Cell shown at pixel position pix; column 0 sits in the MSB of the row.
   function automatic logic cell_at(input logic [WIDTH-1:0] bits,
                                    input logic [PW-1:0]    pix,
                                    input logic             rev);
      logic [PW-1:0] col;
      col = rev ? (LAST_PIX - pix) : pix;
      return bits[LAST_PIX - col];
   endfunction

   assign w_rev           = r_serp && r_row[0];
   // LOAD takes pixel 0 straight from the grid so the first bit starts at once
   assign w_load_color    = cell_at(scan.cells, '0, w_rev) ? r_on : r_off;
   assign w_next_color    = cell_at(r_row_bits, r_pix + PW'(1), w_rev) ? r_on : r_off;
   assign scan.row_select = r_row;
   assign o_busy          = r_busy;

   // Launch decisions for the waveform generator, aligned with FSM transitions
   always_comb begin
      w_start = 1'b0;
      w_latch = 1'b0;
      w_value = 1'b0;
      case (r_state)
         ST_LOAD: begin
            w_start = 1'b1;
            if (!i_enable) w_latch = 1'b1;
            else           w_value = w_load_color[GRB_W-1];
         end
         ST_SEND: begin
            if (!i_enable) begin
               w_start = 1'b1;
               w_latch = 1'b1;
            end else if (w_done) begin
               if (r_bit != LAST_BIT) begin
                  w_start = 1'b1;
                  w_value = r_shift[GRB_W-2];
               end else if (r_pix != LAST_PIX) begin
                  w_start = 1'b1;
                  w_value = w_next_color[GRB_W-1];
               end else if (r_row == LAST_ROW) begin
                  w_start = 1'b1;
                  w_latch = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_row      <= '0;
         r_pix      <= '0;
         r_bit      <= '0;
         r_row_bits <= '0;
         r_shift    <= '0;
         r_on       <= '0;
         r_off      <= '0;
         r_serp     <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_row <= '0;
               if (i_enable && i_frame) begin
                  r_on    <= i_color_on;
                  r_off   <= i_color_off;
                  r_serp  <= i_serpentine;
                  r_busy  <= 1'b1;
                  r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (!i_enable) begin
                  r_state <= ST_LATCH;
               end else begin
                  r_row_bits <= scan.cells;
                  r_shift    <= w_load_color;
                  r_pix      <= '0;
                  r_bit      <= '0;
                  r_state    <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (!i_enable) begin
                  r_state <= ST_LATCH;
               end else if (w_done) begin
                  if (r_bit != LAST_BIT) begin
                     r_bit   <= r_bit + 5'd1;
                     r_shift <= {r_shift[GRB_W-2:0], 1'b0};
                  end else if (r_pix != LAST_PIX) begin
                     r_pix   <= r_pix + PW'(1);
                     r_bit   <= '0;
                     r_shift <= w_next_color;
                  end else if (r_row != LAST_ROW) begin
                     r_row   <= r_row + RW'(1);
                     r_state <= ST_LOAD;
                  end else begin
                     r_state <= ST_LATCH;
                  end
               end
            end
            ST_LATCH: begin
               if (w_done) begin
                  r_row   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   silife_ws2812_bit #(
      .T0H_CYCLES   (T0H_CYCLES),
      .T1H_CYCLES   (T1H_CYCLES),
      .BIT_CYCLES   (BIT_CYCLES),
      .RESET_CYCLES (RESET_CYCLES)
   ) u_bit (
      .clk     (clk),
      .reset   (reset),
      .i_start (w_start),
      .i_latch (w_latch),
      .i_value (w_value),
      .o_done  (w_done),
      .o_data  (o_data)
   );

endmodule

// File: tb/tb_silife_ws2812.sv
// -----------------------------------------------------------------------------
// tb_silife_ws2812
// Randomised bench for silife_ws2812 (WIDTH=4, HEIGHT=2, default timing).
// Stimulus pushes the expected GRB pixel stream of each frame into a queue;
// an independent monitor decodes o_data pulses into pixels and compares.
// -----------------------------------------------------------------------------
module tb_silife_ws2812;

   localparam int W        = 4;
   localparam int H        = 2;
   localparam int T0H      = 4;
   localparam int T1H      = 8;
   localparam int BITC     = 12;
   localparam int RST_C    = 600;
   localparam int FRAME_LEN = H * (1 + W * 24 * BITC) + RST_C;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_enable;
   logic        i_frame;
   logic        i_serpentine;
   logic [23:0] i_color_on;
   logic [23:0] i_color_off;
   logic        o_data;
   logic        o_busy;

   logic [W-1:0] grid [H];

   int n_cmp = 0;
   int n_err = 0;
   logic [23:0] exp_q[$];

   always #5 clk = ~clk;

   silife_ws2812_if #(.WIDTH(W), .HEIGHT(H)) scan_if ();
   assign scan_if.cells = grid[scan_if.row_select];

   silife_ws2812 #(.WIDTH(W), .HEIGHT(H)) dut (
      .clk          (clk),
      .reset        (rst_n),
      .i_enable     (i_enable),
      .i_frame      (i_frame),
      .i_serpentine (i_serpentine),
      .i_color_on   (i_color_on),
      .i_color_off  (i_color_off),
      .scan         (scan_if),
      .o_data       (o_data),
      .o_busy       (o_busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: timeout waiting on DUT", name);
   endtask

   // Reference: pixel order is row by row; odd rows run right-to-left in
   // serpentine mode. Cell (r,c) lives in grid[r] bit W-1-c.
   task automatic push_pixels(input logic [23:0] on, input logic [23:0] off,
                              input bit serp, input int n);
      int k = 0;
      for (int r = 0; r < H; r++) begin
         for (int p = 0; p < W; p++) begin
            if (k < n) begin
               int col;
               logic [W-1:0] rowv;
               col  = (serp && (r % 2 == 1)) ? (W - 1 - p) : p;
               rowv = grid[r];
               exp_q.push_back(rowv[W-1-col] ? on : off);
               k++;
            end
         end
      end
   endtask

   task automatic wait_busy_rise(input string name);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (o_busy) return;
      end
      fail_timeout(name);
   endtask

   // Continues counting busy-high samples from start_len; returns at the first
   // sample with busy low.
   task automatic measure_busy(input int start_len, input int exp_len, input string name);
      int len = start_len;
      for (int i = 0; i < exp_len + 100; i++) begin
         @(negedge clk);
         if (!o_busy) begin
            check(name, len, exp_len);
            return;
         end
         len++;
      end
      fail_timeout(name);
   endtask

   task automatic run_frame(input logic [23:0] on, input logic [23:0] off,
                            input bit serp, input string name);
      @(negedge clk);
      i_color_on   = on;
      i_color_off  = off;
      i_serpentine = serp;
      push_pixels(on, off, serp, W * H);
      i_frame = 1'b1;
      wait_busy_rise(name);
      i_frame = 1'b0;
      measure_busy(1, FRAME_LEN, name);
   endtask

   // ---------------------------------------------------------------- monitor
   logic        m_prev_d;
   int          m_high, m_cyc, m_bit_idx, m_nbits, m_pix;
   logic [23:0] m_acc;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_prev_d  = 1'b0;
         m_high    = 0;
         m_cyc     = 0;
         m_bit_idx = 0;
         m_nbits   = 0;
         m_acc     = '0;
         check("reset_data", {31'd0, o_data}, 32'd0);
      end else if (!o_busy) begin
         check("idle_data", {31'd0, o_data}, 32'd0);
         m_bit_idx = 0;
         m_nbits   = 0;     // drops a partial pixel left by an abort
         m_prev_d  = 1'b0;
      end else begin
         if (o_data && !m_prev_d) begin
            if (m_bit_idx > 0)
               check("bit_period", m_cyc,
                     ((m_bit_idx % (W * 24)) == 0) ? BITC + 1 : BITC);
            m_cyc  = 1;
            m_high = 1;
         end else begin
            m_cyc++;
            if (o_data) m_high++;
         end
         if (!o_data && m_prev_d) begin
            logic b;
            if (m_high == T1H) b = 1'b1;
            else begin
               b = 1'b0;
               check("pulse_width", m_high, T0H);
            end
            m_acc = {m_acc[22:0], b};
            m_nbits++;
            m_bit_idx++;
            if (m_nbits == 24) begin
               m_nbits = 0;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL pixel: got %06h expected none", m_acc);
               end else begin
                  logic [23:0] e;
                  e = exp_q.pop_front();
                  $display("pixel %0d: got %06h expected %06h", m_pix, m_acc, e);
                  check("pixel", {8'd0, m_acc}, {8'd0, e});
               end
               m_pix++;
            end
         end
         m_prev_d = o_data;
      end
   end

   initial m_pix = 0;

   initial begin
      #20000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // --------------------------------------------------------------- stimulus
   initial begin
      logic [23:0] on_a, off_a;
      int cnt;

      // Reset held with a frame request pending
      rst_n        = 1'b0;
      i_enable     = 1'b1;
      i_frame      = 1'b1;
      i_serpentine = 1'b0;
      i_color_on   = 24'hFF0000;
      i_color_off  = 24'h000000;
      grid[0]      = 4'b1000;   // only cell (0,0) live
      grid[1]      = 4'b0000;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("reset_busy", {31'd0, o_busy}, 32'd0);
         check("reset_row", {31'd0, scan_if.row_select}, 32'd0);
      end
      push_pixels(24'hFF0000, 24'h000000, 1'b0, W * H);
      rst_n = 1'b1;
      @(negedge clk);
      check("start_busy", {31'd0, o_busy}, 32'd1);
      check("start_data_low", {31'd0, o_data}, 32'd0);
      i_frame = 1'b0;
      @(negedge clk);
      check("first_rise", {31'd0, o_data}, 32'd1);
      measure_busy(2, FRAME_LEN, "single_pixel_len");
      check("idle_row", {31'd0, scan_if.row_select}, 32'd0);

      // Serpentine placement on row 1
      grid[0] = 4'b0000;
      grid[1] = 4'b1000;
      run_frame(24'h00FF00, 24'h000001, 1'b1, "serp_on_len");
      run_frame(24'h00FF00, 24'h000001, 1'b0, "serp_off_len");

      // Random frames
      for (int f = 0; f < 3; f++) begin
         grid[0] = 4'($urandom);
         grid[1] = 4'($urandom);
         run_frame(24'($urandom), 24'($urandom), 1'($urandom), "rand_len");
      end

      // Colour latching: inputs change mid-frame
      grid[0] = 4'b1010;
      grid[1] = 4'b0110;
      on_a    = 24'($urandom) | 24'h800000;
      off_a   = 24'($urandom) & 24'h7FFFFF;
      @(negedge clk);
      i_color_on   = on_a;
      i_color_off  = off_a;
      i_serpentine = 1'b1;
      push_pixels(on_a, off_a, 1'b1, W * H);
      i_frame = 1'b1;
      wait_busy_rise("latch_colour_start");
      i_frame = 1'b0;
      repeat (200) @(negedge clk);
      i_color_on   = ~on_a;
      i_color_off  = ~off_a;
      i_serpentine = 1'b0;
      measure_busy(201, FRAME_LEN, "latch_colour_len");

      // Abort during row 0, pixel 2 (low phase of its 6th bit)
      grid[0] = 4'($urandom);
      grid[1] = 4'($urandom);
      @(negedge clk);
      i_color_on   = 24'($urandom);
      i_color_off  = 24'($urandom);
      i_serpentine = 1'b0;
      push_pixels(i_color_on, i_color_off, 1'b0, 2);
      i_frame = 1'b1;
      wait_busy_rise("abort_start");
      i_frame = 1'b0;
      repeat (1 + 53 * BITC + 8) @(negedge clk);
      i_enable = 1'b0;
      @(negedge clk);
      check("abort_data_next", {31'd0, o_data}, 32'd0);
      cnt = 0;
      for (int i = 0; i < RST_C + 100; i++) begin
         if (!o_busy) break;
         if (o_data) check("abort_data_low", {31'd0, o_data}, 32'd0);
         cnt++;
         @(negedge clk);
      end
      check("abort_latch_len", cnt, RST_C);
      check("abort_busy_end", {31'd0, o_busy}, 32'd0);
      i_enable = 1'b1;

      // Back-to-back frames with i_frame held high
      grid[0] = 4'($urandom);
      grid[1] = 4'($urandom);
      @(negedge clk);
      i_color_on   = 24'($urandom);
      i_color_off  = 24'($urandom);
      i_serpentine = 1'b1;
      push_pixels(i_color_on, i_color_off, 1'b1, W * H);
      push_pixels(i_color_on, i_color_off, 1'b1, W * H);
      i_frame = 1'b1;
      wait_busy_rise("b2b_start");
      measure_busy(1, FRAME_LEN, "b2b_first_len");
      check("b2b_row_zero", {31'd0, scan_if.row_select}, 32'd0);
      @(negedge clk);
      check("b2b_restart", {31'd0, o_busy}, 32'd1);
      i_frame = 1'b0;
      measure_busy(1, FRAME_LEN, "b2b_second_len");

      repeat (20) @(negedge clk);
      check("queue_empty", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
